// File: rtl/power_pkg.sv
// Shared power-subsystem definitions: converter mode codes, PWM sequencer states, counter width.
package power_pkg;

    localparam int unsigned PWM_CNT_W = 10;
    localparam int unsigned MODE_W    = 3;

    localparam logic [MODE_W-1:0] MODE_OFF   = 3'd0;
    localparam logic [MODE_W-1:0] MODE_BUCK  = 3'd1;
    localparam logic [MODE_W-1:0] MODE_BOOST = 3'd2;
    localparam logic [MODE_W-1:0] MODE_LED   = 3'd3;
    localparam logic [MODE_W-1:0] MODE_HOLD  = 3'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SOFT  = 2'd2,
        RUN   = 2'd3
    } pwm_fsm_t;

    // True for the modes that actually switch a converter.
    function automatic logic mode_drives(input logic [MODE_W-1:0] mode);
        return (mode == MODE_BUCK) || (mode == MODE_BOOST) || (mode == MODE_LED);
    endfunction

endpackage

// File: rtl/pwm_period_counter.sv
// Free-running PWM period counter with boundary flag (last count) and registered period-start strobe.
module pwm_period_counter
    import power_pkg::*;
#(
    parameter int unsigned CNT_W = PWM_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    output logic [CNT_W-1:0] cnt_next_c,
    output logic             boundary_c,
    output logic             period_start_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = '1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             period_start_q;
    logic             period_start_d;

    always_comb begin
        boundary_c     = (cnt_q == CNT_LAST);
        cnt_d          = cnt_q + CNT_W'(1);
        period_start_d = boundary_c;
        cnt_next_c     = cnt_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q          <= '0;
            period_start_q <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            period_start_q <= period_start_d;
        end
    end

    assign period_start_o = period_start_q;

endmodule

// File: rtl/smps_pwm_gen.sv
// Gated PWM generator for buck/boost/LED converters; every mode change is sequenced
// through one blanking period and a soft-start ramp.
module smps_pwm_gen
    import power_pkg::*;
#(
    parameter int unsigned      CNT_W    = PWM_CNT_W,
    parameter logic [CNT_W-1:0] DUTY_MIN = CNT_W'(20),
    parameter logic [CNT_W-1:0] DUTY_MAX = CNT_W'(1000),
    parameter logic [CNT_W-1:0] SS_STEP  = CNT_W'(8)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CNT_W-1:0]  val,
    input  logic [MODE_W-1:0] state_number,
    output logic              buck_pwm,
    output logic              boost_pwm,
    output logic              led_pwm,
    output logic              period_start,
    output logic [CNT_W-1:0]  duty_applied,
    output logic [MODE_W-1:0] active_state
);

    logic [CNT_W-1:0]  cnt_next;
    logic              boundary;

    pwm_fsm_t          state_q,  state_d;
    logic [MODE_W-1:0] active_q, active_d;
    logic [CNT_W-1:0]  duty_q,   duty_d;
    logic              buck_q,   buck_d;
    logic              boost_q,  boost_d;
    logic              led_q,    led_d;

    logic [CNT_W-1:0]  target;
    logic [CNT_W:0]    soft_sum;
    logic              pwm_on;

    pwm_period_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk            (clk),
        .reset          (reset),
        .cnt_next_c     (cnt_next),
        .boundary_c     (boundary),
        .period_start_o (period_start)
    );

    always_comb begin
        if (val < DUTY_MIN) begin
            target = DUTY_MIN;
        end else if (val > DUTY_MAX) begin
            target = DUTY_MAX;
        end else begin
            target = val;
        end
    end

    // Sequencer: state, mode and duty only move on the last count of a period.
    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        duty_d   = duty_q;
        soft_sum = {1'b0, duty_q} + {1'b0, SS_STEP};

        if (boundary) begin
            if (state_number != active_q) begin
                state_d  = BLANK;
                active_d = state_number;
                duty_d   = '0;
            end else begin
                case (state_q)
                    BLANK: begin
                        if (mode_drives(active_q)) begin
                            state_d = SOFT;
                            duty_d  = DUTY_MIN;
                        end else begin
                            state_d = IDLE;
                            duty_d  = '0;
                        end
                    end
                    SOFT: begin
                        if (soft_sum >= {1'b0, target}) begin
                            state_d = RUN;
                            duty_d  = target;
                        end else begin
                            duty_d  = soft_sum[CNT_W-1:0];
                        end
                    end
                    RUN: begin
                        duty_d = target;
                    end
                    default: begin
                        state_d = IDLE;
                        duty_d  = '0;
                    end
                endcase
            end
        end

        // PWM registers see next-cycle count/duty so the pin lines up with cnt.
        pwm_on  = ((state_d == SOFT) || (state_d == RUN)) && (cnt_next < duty_d);
        buck_d  = pwm_on && (active_d == MODE_BUCK);
        boost_d = pwm_on && (active_d == MODE_BOOST);
        led_d   = pwm_on && (active_d == MODE_LED);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            active_q <= MODE_OFF;
            duty_q   <= '0;
            buck_q   <= 1'b0;
            boost_q  <= 1'b0;
            led_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            duty_q   <= duty_d;
            buck_q   <= buck_d;
            boost_q  <= boost_d;
            led_q    <= led_d;
        end
    end

    assign buck_pwm     = buck_q;
    assign boost_pwm    = boost_q;
    assign led_pwm      = led_q;
    assign duty_applied = duty_q;
    assign active_state = active_q;

    a_one_hot_pwm: assert property (@(posedge clk) disable iff (reset)
        $onehot0({buck_q, boost_q, led_q}));

endmodule
